wb_arb2: RTL
============

Name: wb_arb2

Overview:
- Two-master Wishbone arbiter in front of one shared 16-bit register-block slave (parreg16 class, ADRBITS address bits).
- Lets two controllers share one configuration register bank without bus collisions: e.g. the host-interface decoder and the local trigger/sequencer logic.
- Grants round-robin and holds each grant for the whole bus cycle.
- A watchdog terminates a strobe the slave never acknowledges.

Parameters:
- ADRBITS, 1, address width of the shared slave.
- TMO_BITS, 8, watchdog counter width; timeout after 2**TMO_BITS-1 cycles with strobe and no ack.

Ports:
- wb_clk  in  1  bus clock.
- wb_rst_n  in  1  reset, asynchronous, active-low.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write.
- m0_adr  in  ADRBITS  master 0 address.
- m0_dat_i  in  16  master 0 write data.
- m0_dat_o  out  16  master 0 read data.
- m0_ack, m0_err  out  1 each  master 0 terminations.
- m1_*  same set as m0_*  master 1.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  ADRBITS  to slave.
- s_dat_o  out  16  write data to slave.
- s_dat_i  in  16  read data from slave.
- s_ack  in  1  slave ack.
- gnt  out  2  one-hot current grant, 00 = idle.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, gnt=00, priority pointer favours m0, watchdog=0.
  - Slave-side controls 0; m*_ack/m*_err 0.
  - Reset mid-cycle aborts the cycle silently; no ack or err is issued.
- States:
  - IDLE -> GNT0 or GNT1 on the clock edge after any m*_cyc is seen high.
  - Both requesting: grant the master not served last (pointer). After reset the pointer favours m0.
  - GNTx -> IDLE on the edge where mx_cyc is sampled low.
  - IDLE lasts at least one cycle between grants; no back-to-back handover.
  - Arbitration latency: request in cycle n -> gnt valid from cycle n+1.
- Datapath, combinational from gnt:
  - s_cyc = mx_cyc & gntx; s_stb = mx_stb & gntx.
  - s_we, s_adr, s_dat_o muxed from the granted master; all 0 when idle.
  - mx_dat_o = s_dat_i while granted, else 0.
  - mx_ack = s_ack & gntx & mx_stb.
  - The non-granted master never sees ack, err or data.
- Pointer: updates when a grant is issued; it then favours the other master.
- Watchdog:
  - Counts while s_stb=1 and s_ack=0.
  - Clears on s_ack, on stb low, and on grant change.
  - Reaching 2**TMO_BITS-1: mx_err pulses high for exactly one cycle; the counter clears.
  - The grant is held until the master drops cyc.
  - A s_ack arriving in the same cycle as the terminal count wins: ack is issued, err is not.
- Slave ack handling:
  - An ack arriving with no grant, or after the master's stb has dropped, is discarded.
  - The slave acks one cycle after stb (registered); a master holding stb across several beats receives one ack per slave ack.
- Master dropping cyc while its stb is pending: grant is released next edge; any late ack is discarded.
- Both masters raising cyc in the same cycle as a grant release: that cycle remains IDLE; the pointer decides the next grant.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE, ST_GNT0, ST_GNT1.
  - Grant encoding constants GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10.
- Sub-module wb_watchdog (parameter TMO_BITS):
  - Inputs clk, rst_n, run, clr.
  - Output one-cycle expire pulse.
  - Holds the counter, so the arbiter core is FSM plus mux only.

Test Plan:
- Reset release, m0 writes 0xA5A5 to adr 0: gnt=01 one cycle after cyc; s_we=1, s_dat_o=0xA5A5; m0_ack one cycle after stb; gnt=00 after cyc drops.
- Both cyc high together from reset: m0 is served first. After m0 drops cyc there is one IDLE cycle, then gnt=10. Sequence 01,00,10.
- m1 holds cyc for 3 reads while m0 requests: m0 stalls with no ack for all 3 reads; m1 reads back prior writes 0x1234/0xBEEF correctly; m0 is granted after m1 releases.
- Slave ack tied low, TMO_BITS=4, m0 strobes: m0_err high for exactly one cycle, at cycle 15 after stb; m0_ack never high; gnt stays 01 until cyc drops.
- wb_rst_n pulsed low mid-write while gnt=10: gnt, s_cyc, s_stb and m1_ack go 0 asynchronously before the next wb_clk edge. After release the next simultaneous request is granted to m0.
- Injected spurious s_ack while idle, and a late ack after m0 dropped stb: no m*_ack asserts in either case.

Source files
------------

// File: rtl/wb_arb2_pkg.sv
// Shared encodings for the two-master Wishbone arbiter.
package wb_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb2_watchdog.sv
// Strobe watchdog: counts unacknowledged strobe cycles and pulses expire
// for one cycle when the count reaches its all-ones terminal value.
module wb_watchdog #(
    parameter int TMO_BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam logic [TMO_BITS-1:0] CNT_MAX = '1;

    logic [TMO_BITS-1:0] cnt;

    // run already excludes a same-cycle ack, so an ack at terminal count wins
    assign expire = run & ~clr & (cnt == CNT_MAX);

    // Count stalled strobe cycles; restart on clear, idle strobe, or expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || !run || expire)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter for one shared 16-bit register slave.
// Grant is held for the whole bus cycle; a watchdog errors out a dead strobe.
module wb_arb2
    import wb_arb2_pkg::*;
#(
    parameter int ADRBITS  = 1,
    parameter int TMO_BITS = 8
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    input  logic               m0_cyc,
    input  logic               m0_stb,
    input  logic               m0_we,
    input  logic [ADRBITS-1:0] m0_adr,
    input  logic [15:0]        m0_dat_i,
    output logic [15:0]        m0_dat_o,
    output logic               m0_ack,
    output logic               m0_err,
    input  logic               m1_cyc,
    input  logic               m1_stb,
    input  logic               m1_we,
    input  logic [ADRBITS-1:0] m1_adr,
    input  logic [15:0]        m1_dat_i,
    output logic [15:0]        m1_dat_o,
    output logic               m1_ack,
    output logic               m1_err,
    output logic               s_cyc,
    output logic               s_stb,
    output logic               s_we,
    output logic [ADRBITS-1:0] s_adr,
    output logic [15:0]        s_dat_o,
    input  logic [15:0]        s_dat_i,
    input  logic               s_ack,
    output logic [1:0]         gnt
);

    state_t state, state_nxt;
    logic   ptr, ptr_nxt;   // 0: favour m0 on contention, 1: favour m1
    logic   g0, g1;
    logic   wd_run, wd_clr, wd_exp;

    // State and round-robin pointer registers
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Grant decision from IDLE only, so every handover passes through IDLE
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE: begin
                if (m0_cyc && (!m1_cyc || !ptr)) begin
                    state_nxt = ST_GNT0;
                    ptr_nxt   = 1'b1;
                end else if (m1_cyc) begin
                    state_nxt = ST_GNT1;
                    ptr_nxt   = 1'b0;
                end
            end
            ST_GNT0: if (!m0_cyc) state_nxt = ST_IDLE;
            ST_GNT1: if (!m1_cyc) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign gnt = (state == ST_GNT0) ? GNT_M0 :
                 (state == ST_GNT1) ? GNT_M1 : GNT_NONE;
    assign g0  = gnt[0];
    assign g1  = gnt[1];

    // Slave-side mux: AND-OR so everything reads zero while idle
    assign s_cyc   = (m0_cyc & g0) | (m1_cyc & g1);
    assign s_stb   = (m0_stb & g0) | (m1_stb & g1);
    assign s_we    = (m0_we  & g0) | (m1_we  & g1);
    assign s_adr   = ({ADRBITS{g0}} & m0_adr)   | ({ADRBITS{g1}} & m1_adr);
    assign s_dat_o = ({16{g0}}      & m0_dat_i) | ({16{g1}}      & m1_dat_i);

    // Master-side returns; gating by the master's own stb drops late acks
    assign m0_dat_o = g0 ? s_dat_i : 16'h0000;
    assign m1_dat_o = g1 ? s_dat_i : 16'h0000;
    assign m0_ack   = s_ack & g0 & m0_stb;
    assign m1_ack   = s_ack & g1 & m1_stb;
    assign m0_err   = wd_exp & g0 & m0_stb;
    assign m1_err   = wd_exp & g1 & m1_stb;

    assign wd_run = s_stb & ~s_ack;
    assign wd_clr = (state_nxt != state);

    wb_watchdog #(.TMO_BITS(TMO_BITS)) u_wd (
        .clk    (wb_clk),
        .rst_n  (wb_rst_n),
        .run    (wd_run),
        .clr    (wd_clr),
        .expire (wd_exp)
    );

endmodule
